rsa_req_arbiter: RTL and testbench
==================================

RSA_REQ_ARBITER -- requirements
Module: rsa_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, maximum WAIT-state cycles before abort (used only under RSA_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a job.
REQ-005 reqN_ready  output  1  job from requester N accepted this cycle.
REQ-006 reqN_cmd  input  2  01 encrypt, 10 decrypt, 00/11 invalid.
REQ-007 reqN_msg  input  65  operand.
REQ-008 rspN_valid  output  1  result for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes result.
REQ-010 rspN_data  output  65  result.
REQ-011 rspN_err  output  1  job rejected or aborted; rspN_data is 0.
REQ-012 eng_msg  output  65  operand to the exponentiation engine.
REQ-013 eng_cmd  output  2  engine command; 00 except during ISSUE.
REQ-014 eng_result  input  65  engine result.
REQ-015 eng_sync  input  1  engine one-cycle done pulse.
REQ-016 eng_abort  output  1  one-cycle engine-reset request.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 States: IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-019 IDLE: grant one valid requester; reqN_ready combinational, high only for the granted N, and only in IDLE.
REQ-020 Arbitration: round-robin; a single valid requester wins; if both are valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-021 On accept with cmd 01/10: latch msg, cmd, and owner; go to ISSUE.
REQ-022 On accept with cmd 00/11: latch owner and set err=1, data=0; go directly to RESP; the engine is not touched.
REQ-023 ISSUE lasts exactly one cycle, driving eng_cmd=latched cmd and eng_msg=latched msg; then WAIT.
REQ-024 eng_msg holds the latched operand from ISSUE until the next accept.
REQ-025 WAIT: on eng_sync=1, capture eng_result and set err=0; go to RESP.
REQ-026 eng_sync in IDLE, ISSUE, or RESP is ignored.
REQ-027 RESP: assert rspN_valid for the owner only, holding data and err stable until rspN_ready=1.
REQ-028 On the cycle rspN_valid and rspN_ready are both 1: go to IDLE and record the owner as last granted.
REQ-029 Latency: accept at edge T; eng_cmd valid during cycle T+1; rspN_valid rises the cycle after eng_sync; the invalid-cmd response rises at cycle T+1.
REQ-030 No new request is accepted while busy=1, including while the response is back-pressured.

Reset
REQ-031 rst=1 forces, immediately: state IDLE, last-granted=1 (requester 0 priority), all reqN_ready, rspN_valid, and rspN_err 0, rspN_data 0, eng_cmd 00, eng_msg 0, eng_abort 0, busy 0, timeout counter 0.
REQ-032 Reset mid-job discards the job without a response; a later eng_sync is ignored per REQ-026.

Configuration
REQ-033 Macro RSA_ARB_TIMEOUT_EN defined: WAIT counts cycles from 0.
REQ-034 If the count reaches TIMEOUT_CYCLES without eng_sync: pulse eng_abort for one cycle, respond err=1 and data=0, and go to RESP.
REQ-035 If eng_sync and the timeout occur in the same cycle, eng_sync wins.
REQ-036 Macro undefined: no counter, eng_abort tied 0, WAIT has no time limit.

Verification
REQ-037 Engine model with e=17 returns msg^17 mod n; req0 encrypt msg=2 -> eng_cmd=01 for exactly one cycle, rsp0_data=131072, rsp0_err=0.
REQ-038 req1 decrypt msg=131072 -> eng_cmd=10 for exactly one cycle, rsp1_data=2.
REQ-039 req0 and req1 both valid in the first cycle after reset -> req0 served first, then req1; both valid again -> req0 first (alternation).
REQ-040 req0 cmd=11 -> rsp0_valid at T+1 with err=1 and data=0; eng_cmd stays 00 throughout.
REQ-041 rsp0_ready held low 10 cycles -> rsp0_data stable, req1_ready stays 0, busy=1; release -> IDLE next cycle.
REQ-042 Macro defined, TIMEOUT_CYCLES=16, eng_sync never pulsed -> eng_abort pulses after 16 WAIT cycles, rsp err=1; rst asserted in WAIT -> all outputs reset, no response.

Source files
------------

// File: rtl/rsa_req_arbiter.sv
// Two-requester round-robin front end for a single RSA exponentiation engine.
// Optional WAIT-state watchdog enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_cmd,
  input  logic [64:0] req0_msg,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_cmd,
  input  logic [64:0] req1_msg,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [64:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [64:0] rsp1_data,
  output logic        rsp1_err,
  output logic [64:0] eng_msg,
  output logic [1:0]  eng_cmd,
  input  logic [64:0] eng_result,
  input  logic        eng_sync,
  output logic        eng_abort,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  eng_cmd_q, eng_cmd_d;
  logic [64:0] eng_msg_q, eng_msg_d;
  logic [64:0] data_q, data_d;
  logic        err_q, err_d;
  logic        gnt0_s, gnt1_s;
  logic [1:0]  sel_cmd_s;
  logic [64:0] sel_msg_s;
  logic        cmd_ok_s;
  logic        rsp_take_s;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = ^TIMEOUT_CYCLES;
`endif

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if ((state_q == S_IDLE) && !rst) begin
      if (req0_valid && (!req1_valid || last_q)) begin
        gnt0_s = 1'b1;
      end else if (req1_valid) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt1_s = 1'b0;
    end
  end

  assign sel_cmd_s  = gnt1_s ? req1_cmd : req0_cmd;
  assign sel_msg_s  = gnt1_s ? req1_msg : req0_msg;
  assign cmd_ok_s   = (sel_cmd_s == 2'b01) || (sel_cmd_s == 2'b10);
  assign rsp_take_s = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state and datapath capture for the single in-flight job.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    eng_cmd_d = 2'b00;
    eng_msg_d = eng_msg_q;
    data_d    = data_q;
    err_d     = err_q;
`ifdef RSA_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          owner_d = gnt1_s;
          if (cmd_ok_s) begin
            eng_cmd_d = sel_cmd_s;
            eng_msg_d = sel_msg_s;
            state_d   = S_ISSUE;
          end else begin
            data_d  = 65'd0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
`ifdef RSA_ARB_TIMEOUT_EN
        cnt_d   = {CNT_W{1'b0}};
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the same cycle as the timeout takes precedence.
        if (eng_sync) begin
          data_d  = eng_result;
          err_d   = 1'b0;
          state_d = S_RESP;
`ifdef RSA_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_d = 1'b1;
          data_d  = 65'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        if (rsp_take_s) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset leaves requester 0 with priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      eng_cmd_q <= 2'b00;
      eng_msg_q <= 65'd0;
      data_q    <= 65'd0;
      err_q     <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q     <= {CNT_W{1'b0}};
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      eng_cmd_q <= eng_cmd_d;
      eng_msg_q <= eng_msg_d;
      data_q    <= data_d;
      err_q     <= err_d;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
`endif
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign busy       = (state_q != S_IDLE);
  assign eng_cmd    = eng_cmd_q;
  assign eng_msg    = eng_msg_q;
  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) && owner_q;
  assign rsp0_data  = rsp0_valid ? data_q : 65'd0;
  assign rsp1_data  = rsp1_valid ? data_q : 65'd0;
  assign rsp0_err   = rsp0_valid ? err_q : 1'b0;
  assign rsp1_err   = rsp1_valid ? err_q : 1'b0;

`ifdef RSA_ARB_TIMEOUT_EN
  assign eng_abort = abort_q;
`else
  assign eng_abort = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// Self-checking bench for rsa_req_arbiter: directed scenarios plus randomized jobs
// checked against an RSA (n=503*509, e=17, d=15001) and round-robin reference model.
module tb_rsa_req_arbiter;

  localparam longint unsigned NMOD = 64'd256027;
  localparam int unsigned E_PUB = 17;
  localparam int unsigned D_PRV = 15001;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_cmd, req1_cmd;
  logic [64:0] req0_msg, req1_msg;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [64:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [64:0] eng_msg;
  logic [1:0]  eng_cmd;
  logic [64:0] eng_result;
  logic        eng_sync;
  logic        eng_abort;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int last_served = 1;

  rsa_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_msg(req0_msg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_msg(req1_msg),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .eng_msg(eng_msg), .eng_cmd(eng_cmd), .eng_result(eng_result), .eng_sync(eng_sync),
    .eng_abort(eng_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] modexp(input logic [64:0] base, input int unsigned e);
    longint unsigned r, x;
    int unsigned k;
    r = 64'd1;
    x = base[63:0] % NMOD;
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % NMOD;
      x = (x * x) % NMOD;
      k = k >> 1;
    end
    return {1'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full job: present requests, play engine, check response and back-pressure.
  task automatic run_job(input logic v0, input logic v1, input logic [1:0] c0, input logic [1:0] c1,
                         input logic [64:0] m0, input logic [64:0] m1, input int dly, input int bp,
                         input string tag);
    int w;
    logic [1:0] c;
    logic [64:0] m, exp_d;
    logic exp_e, rv, ov;
    logic [64:0] rd;
    w = (v0 && v1) ? ((last_served == 1) ? 0 : 1) : (v0 ? 0 : 1);
    c = (w == 1) ? c1 : c0;
    m = (w == 1) ? m1 : m0;
    @(negedge clk);
    req0_valid = v0; req0_cmd = c0; req0_msg = m0;
    req1_valid = v1; req1_cmd = c1; req1_msg = m1;
    #1;
    chk({tag, ":ready0"}, {64'd0, req0_ready}, {64'd0, (w == 0)});
    chk({tag, ":ready1"}, {64'd0, req1_ready}, {64'd0, (w == 1)});
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (c == 2'b01 || c == 2'b10) begin
      exp_d = modexp(m, (c == 2'b01) ? E_PUB : D_PRV);
      exp_e = 1'b0;
      chk({tag, ":issue_cmd"}, {63'd0, eng_cmd}, {63'd0, c});
      chk({tag, ":issue_msg"}, eng_msg, m);
      step();
      chk({tag, ":cmd_one_cycle"}, {63'd0, eng_cmd}, 65'd0);
      for (int i = 0; i < dly; i++) step();
      chk({tag, ":wait_no_rsp"}, {63'd0, rsp1_valid, rsp0_valid}, 65'd0);
      eng_sync = 1'b1;
      eng_result = exp_d;
      step();
      eng_sync = 1'b0;
      eng_result = {1'b1, $urandom, $urandom};
    end else begin
      exp_d = 65'd0;
      exp_e = 1'b1;
      chk({tag, ":inv_no_cmd"}, {63'd0, eng_cmd}, 65'd0);
    end
    rv = (w == 1) ? rsp1_valid : rsp0_valid;
    ov = (w == 1) ? rsp0_valid : rsp1_valid;
    rd = (w == 1) ? rsp1_data : rsp0_data;
    chk({tag, ":rsp_valid"}, {64'd0, rv}, 65'd1);
    chk({tag, ":rsp_other"}, {64'd0, ov}, 65'd0);
    chk({tag, ":rsp_data"}, rd, exp_d);
    chk({tag, ":rsp_err"}, {64'd0, (w == 1) ? rsp1_err : rsp0_err}, {64'd0, exp_e});
    chk({tag, ":abort_idle"}, {64'd0, eng_abort}, 65'd0);
    for (int i = 0; i < bp; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      eng_sync = (i == 0);
      #1;
      chk({tag, ":bp_ready"}, {63'd0, req1_ready, req0_ready}, 65'd0);
      step();
      eng_sync = 1'b0;
      chk({tag, ":bp_data"}, (w == 1) ? rsp1_data : rsp0_data, exp_d);
      chk({tag, ":bp_busy"}, {64'd0, busy}, 65'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (w == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk({tag, ":idle_busy"}, {64'd0, busy}, 65'd0);
    chk({tag, ":idle_rsp"}, {63'd0, rsp1_valid, rsp0_valid}, 65'd0);
    last_served = w;
  endtask

  initial begin
    int n_wait;
    logic [1:0] rc0, rc1;
    logic rv0, rv1;
    rst = 1'b1;
    req0_valid = 1'b1; req0_cmd = 2'b01; req0_msg = 65'd7;
    req1_valid = 1'b0; req1_cmd = 2'b00; req1_msg = 65'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    eng_result = 65'd0; eng_sync = 1'b0;
    #1;
    chk("rst_ready", {63'd0, req1_ready, req0_ready}, 65'd0);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_rsp", {61'd0, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}, 65'd0);
    chk("rst_eng", {62'd0, eng_abort, eng_cmd}, 65'd0);
    chk("rst_msg", eng_msg, 65'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;

    run_job(1'b1, 1'b1, 2'b01, 2'b01, 65'd3, 65'd4, 1, 0, "rr_a0");
    run_job(1'b1, 1'b1, 2'b01, 2'b10, 65'd5, 65'd6, 2, 0, "rr_a1");
    run_job(1'b1, 1'b1, 2'b10, 2'b01, 65'd8, 65'd9, 0, 0, "rr_b0");
    run_job(1'b1, 1'b1, 2'b01, 2'b01, 65'd10, 65'd11, 1, 0, "rr_b1");
    run_job(1'b1, 1'b0, 2'b01, 2'b00, 65'd2, 65'd0, 3, 0, "enc2");
    run_job(1'b0, 1'b1, 2'b00, 2'b10, 65'd0, 65'd131072, 2, 0, "dec131072");
    run_job(1'b1, 1'b0, 2'b11, 2'b00, 65'd9, 65'd0, 0, 0, "inv11");
    run_job(1'b0, 1'b1, 2'b00, 2'b00, 65'd0, 65'd9, 0, 0, "inv00");
    run_job(1'b1, 1'b0, 2'b01, 2'b00, 65'd12345, 65'd0, 1, 10, "backpressure");

    // Reset in WAIT: job discarded, late eng_sync ignored.
    @(negedge clk);
    req0_valid = 1'b1; req0_cmd = 2'b01; req0_msg = 65'd77;
    step();
    req0_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstwait_busy", {64'd0, busy}, 65'd0);
    chk("rstwait_eng", {62'd0, eng_abort, eng_cmd}, 65'd0);
    chk("rstwait_msg", eng_msg, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    last_served = 1;
    eng_sync = 1'b1;
    eng_result = 65'd999;
    step();
    eng_sync = 1'b0;
    chk("rstwait_no_rsp", {62'd0, busy, rsp1_valid, rsp0_valid}, 65'd0);

`ifdef RSA_ARB_TIMEOUT_EN
    @(negedge clk);
    req1_valid = 1'b1; req1_cmd = 2'b10; req1_msg = 65'd55;
    step();
    req1_valid = 1'b0;
    n_wait = 0;
    while (n_wait < 100 && eng_abort !== 1'b1) begin
      step();
      n_wait++;
    end
    chk("to_cycles", 65'(n_wait), 65'd17);
    chk("to_rsp", {63'd0, rsp1_valid, rsp1_err}, 65'd3);
    chk("to_data", rsp1_data, 65'd0);
    step();
    chk("to_pulse", {64'd0, eng_abort}, 65'd0);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    chk("to_idle", {64'd0, busy}, 65'd0);
    last_served = 1;
`else
    n_wait = 0;
`endif

    for (int it = 0; it < 16; it++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      rc0 = ($urandom_range(0, 4) == 0) ? 2'b11 : 2'($urandom_range(1, 2));
      rc1 = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
      run_job(rv0, rv1, rc0, rc1, 65'($urandom_range(0, 256026)), 65'($urandom_range(0, 256026)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
